// File: rtl/l15_pkg.sv
// Shared encodings and request payload for the L1.5 fetch responder.
package l15_pkg;

    localparam logic [4:0] RQ_LOAD  = 5'd0;
    localparam logic [4:0] RQ_STORE = 5'd1;

    localparam logic [3:0] RET_LOAD      = 4'd0;
    localparam logic [3:0] RET_STORE_ACK = 4'd4;
    localparam logic [3:0] RET_WAKEUP    = 4'd7;

    localparam int unsigned STATE_W = 3;

    // FSM state encoding
    localparam logic [STATE_W-1:0] S_WAKE      = 3'd0;
    localparam logic [STATE_W-1:0] S_WAKE_RESP = 3'd1;
    localparam logic [STATE_W-1:0] S_IDLE      = 3'd2;
    localparam logic [STATE_W-1:0] S_ACK       = 3'd3;
    localparam logic [STATE_W-1:0] S_LAT       = 3'd4;
    localparam logic [STATE_W-1:0] S_RESP      = 3'd5;

    typedef struct packed {
        logic [4:0]  rqtype;
        logic [31:0] address;
        logic [63:0] data;
    } l15_req_t;

endpackage

// File: rtl/l15_line_ram.sv
// Line-organised backing RAM: even/odd doubleword banks, one arbitrated write
// port (preload over store) and a line-wide registered read with write-first bypass.
module l15_line_ram #(
    parameter int unsigned LINES_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_we,
    input  logic [LINES_LOG2:0]   init_idx,
    input  logic [63:0]           init_data,
    input  logic                  st_we,
    input  logic [LINES_LOG2:0]   st_idx,
    input  logic [63:0]           st_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [LINES_LOG2-1:0] rd_line,
    output logic [63:0]           rd_data_0,
    output logic [63:0]           rd_data_1
);

    localparam int unsigned LINES = 1 << LINES_LOG2;
    localparam int unsigned DW_W  = LINES_LOG2 + 1;

    logic [63:0] bank_e [0:LINES-1];
    logic [63:0] bank_o [0:LINES-1];

    logic                  we_c;
    logic [DW_W-1:0]       wr_idx_c;
    logic [63:0]           wr_data_c;
    logic [LINES_LOG2-1:0] wr_line_c;
    logic [63:0]           rd_e_c;
    logic [63:0]           rd_o_c;

    // Preload owns the port whenever it is active.
    always_comb begin
        we_c      = init_we | st_we;
        wr_idx_c  = init_we ? init_idx  : st_idx;
        wr_data_c = init_we ? init_data : st_data;
        wr_line_c = wr_idx_c[DW_W-1:1];
    end

    always_ff @(posedge clk) begin
        if (we_c && !wr_idx_c[0]) bank_e[wr_line_c] <= wr_data_c;
        if (we_c &&  wr_idx_c[0]) bank_o[wr_line_c] <= wr_data_c;
    end

    always_comb begin
        rd_e_c = bank_e[rd_line];
        rd_o_c = bank_o[rd_line];
        if (we_c && !wr_idx_c[0] && wr_line_c == rd_line) rd_e_c = wr_data_c;
        if (we_c &&  wr_idx_c[0] && wr_line_c == rd_line) rd_o_c = wr_data_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_0 <= '0;
            rd_data_1 <= '0;
        end else if (rd_clr) begin
            rd_data_0 <= '0;
            rd_data_1 <= '0;
        end else if (rd_en) begin
            rd_data_0 <= rd_e_c;
            rd_data_1 <= rd_o_c;
        end
    end

endmodule

// File: rtl/l15_fetch_responder.sv
// Responder end of the transducer<->L1.5 interface backed by a local line RAM;
// sends the wake-up packet after reset, then serves one request at a time.
module l15_fetch_responder
    import l15_pkg::*;
#(
    parameter int unsigned LINES_LOG2   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int unsigned RESP_LATENCY = 2,
    parameter int unsigned WAKEUP_DELAY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transducer_l15_val,
    input  logic [4:0]          transducer_l15_rqtype,
    input  logic [2:0]          transducer_l15_size,
    input  logic [31:0]         transducer_l15_address,
    input  logic [63:0]         transducer_l15_data,
    input  logic                transducer_l15_req_ack,
    output logic                l15_transducer_header_ack,
    output logic                l15_transducer_ack,
    output logic                l15_transducer_val,
    output logic [3:0]          l15_transducer_returntype,
    output logic [63:0]         l15_transducer_data_0,
    output logic [63:0]         l15_transducer_data_1,
    input  logic                init_we,
    input  logic [LINES_LOG2:0] init_addr,
    input  logic [63:0]         init_data
);

    localparam int unsigned DW_W    = LINES_LOG2 + 1;
    localparam logic [32:0] SPAN    = 33'(33'd16 << LINES_LOG2);
    localparam int unsigned CNT_MAX = (WAKEUP_DELAY > RESP_LATENCY) ? WAKEUP_DELAY : RESP_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [STATE_W-1:0]    state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx, cnt_inc_c;
    l15_req_t              req_q;
    logic [31:0]           off_c;
    logic                  in_range_c, is_load_c, is_store_c;
    logic                  rsp_entry_c, st_we_c, rd_en_c, rd_clr_c;
    logic [LINES_LOG2-1:0] line_c;
    logic [DW_W-1:0]       st_idx_c;
    logic                  unused_c;

    // Request size does not affect behaviour: loads are line-wide, stores doubleword-wide.
    assign unused_c = ^transducer_l15_size;

    always_comb begin
        off_c       = req_q.address - BASE_ADDR;
        in_range_c  = (req_q.address >= BASE_ADDR) && ({1'b0, off_c} < SPAN);
        is_load_c   = (req_q.rqtype == RQ_LOAD);
        is_store_c  = (req_q.rqtype == RQ_STORE);
        line_c      = off_c[LINES_LOG2+3:4];
        st_idx_c    = {line_c, off_c[3]};
        st_we_c     = (state == S_ACK) && is_store_c && in_range_c;
        rsp_entry_c = (state_nx == S_RESP) && (state != S_RESP);
        rd_en_c     = rsp_entry_c && is_load_c && in_range_c;
        // Response data is zero except while an in-range load is being presented.
        rd_clr_c    = (state_nx != S_RESP) || (rsp_entry_c && !rd_en_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAKE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cnt_inc_c = cnt + CNT_W'(1);
        case (state)
            S_WAKE: begin
                if (cnt_inc_c == CNT_W'(WAKEUP_DELAY)) begin
                    state_nx = S_WAKE_RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc_c;
                end
            end
            S_WAKE_RESP: if (transducer_l15_req_ack) state_nx = S_IDLE;
            S_IDLE:      if (transducer_l15_val && l15_transducer_header_ack) state_nx = S_ACK;
            S_ACK: begin
                cnt_nx   = '0;
                state_nx = (RESP_LATENCY > 1) ? S_LAT : S_RESP;
            end
            S_LAT: begin
                if (cnt_inc_c == CNT_W'(RESP_LATENCY - 1)) begin
                    state_nx = S_RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc_c;
                end
            end
            S_RESP:      if (transducer_l15_req_ack) state_nx = S_IDLE;
            default:     state_nx = S_WAKE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (state == S_IDLE && transducer_l15_val && l15_transducer_header_ack) begin
            req_q <= '{rqtype:  transducer_l15_rqtype,
                       address: transducer_l15_address,
                       data:    transducer_l15_data};
        end
    end

    // Handshake outputs are registered images of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l15_transducer_header_ack <= 1'b0;
            l15_transducer_ack        <= 1'b0;
            l15_transducer_val        <= 1'b0;
            l15_transducer_returntype <= RET_LOAD;
        end else begin
            l15_transducer_header_ack <= (state_nx == S_IDLE);
            l15_transducer_ack        <= (state_nx == S_ACK);
            l15_transducer_val        <= (state_nx == S_WAKE_RESP) || (state_nx == S_RESP);
            if (state_nx == S_WAKE_RESP)
                l15_transducer_returntype <= RET_WAKEUP;
            else if (state_nx == S_RESP)
                l15_transducer_returntype <= is_load_c ? RET_LOAD : RET_STORE_ACK;
            else
                l15_transducer_returntype <= RET_LOAD;
        end
    end

    l15_line_ram #(
        .LINES_LOG2 (LINES_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_idx  (init_addr),
        .init_data (init_data),
        .st_we     (st_we_c),
        .st_idx    (st_idx_c),
        .st_data   (req_q.data),
        .rd_en     (rd_en_c),
        .rd_clr    (rd_clr_c),
        .rd_line   (line_c),
        .rd_data_0 (l15_transducer_data_0),
        .rd_data_1 (l15_transducer_data_1)
    );

endmodule

// File: tb/tb_l15_fetch_responder.sv
// Scoreboard bench for l15_fetch_responder: driver pushes model responses,
// an independent monitor pops and checks them as the responder presents them.
module tb_l15_fetch_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SPAN = 32'h0000_4000;
    localparam int          RL   = 2;
    localparam int          WD   = 4;
    localparam int          NDW  = 2048;

    typedef struct {
        logic [3:0]  rt;
        logic [63:0] d0;
        logic [63:0] d1;
        int          hold;
        int          lat;
        bit          wake;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_val, t_req_ack, header_ack, ack, r_val, init_we;
    logic [4:0]  t_rqtype;
    logic [2:0]  t_size;
    logic [31:0] t_addr;
    logic [63:0] t_data, d0, d1, init_data;
    logic [3:0]  rt;
    logic [10:0] init_addr;

    logic [63:0] mem [0:NDW-1];
    exp_t        sb[$];
    exp_t        cur;
    int          total = 0, bad = 0, cyc = 0, rel_cyc = 0, ack_cyc = 0, left = 0;
    bit          holding = 0, after_ack = 0;

    l15_fetch_responder dut (
        .clk                       (clk),
        .rst                       (rst),
        .transducer_l15_val        (t_val),
        .transducer_l15_rqtype     (t_rqtype),
        .transducer_l15_size       (t_size),
        .transducer_l15_address    (t_addr),
        .transducer_l15_data       (t_data),
        .transducer_l15_req_ack    (t_req_ack),
        .l15_transducer_header_ack (header_ack),
        .l15_transducer_ack        (ack),
        .l15_transducer_val        (r_val),
        .l15_transducer_returntype (rt),
        .l15_transducer_data_0     (d0),
        .l15_transducer_data_1     (d1),
        .init_we                   (init_we),
        .init_addr                 (init_addr),
        .init_data                 (init_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Reference: the RAM is an array of doublewords indexed by (address-BASE)/8.
    task automatic model(input logic [4:0] rq, input logic [31:0] addr, input logic [63:0] d,
                         input int hold, output exp_t e);
        logic [31:0] off;
        bit          inr;
        int          dw;
        off    = addr - BASE;
        inr    = (addr >= BASE) && (off < SPAN);
        dw     = int'(off >> 3);
        e.rt   = (rq == 5'd0) ? 4'd0 : 4'd4;
        e.d0   = '0;
        e.d1   = '0;
        e.hold = hold;
        e.lat  = RL;
        e.wake = 0;
        if (rq == 5'd0 && inr) begin
            e.d0 = mem[(dw / 2) * 2];
            e.d1 = mem[(dw / 2) * 2 + 1];
        end
        if (rq == 5'd1 && inr) mem[dw] = d;
    endtask

    task automatic issue(input logic [4:0] rq, input logic [31:0] addr, input logic [63:0] d,
                         input int hold, input bit collide);
        exp_t        e;
        int          n;
        logic [31:0] off;
        logic [63:0] r;
        model(rq, addr, d, hold, e);
        sb.push_back(e);
        t_val = 1'b1; t_rqtype = rq; t_addr = addr; t_data = d; t_size = 3'($urandom);
        n = 0;
        while (header_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL header_ack_timeout: got no header_ack in %0d cycles", n);
            t_val = 1'b0;
            return;
        end
        @(negedge clk);
        t_val = 1'b0; t_addr = $urandom; t_data = rand64(); t_rqtype = 5'($urandom);
        chk("ack_after_capture", 64'(ack), 64'd1);
        chk("header_ack_in_ack", 64'(header_ack), 64'd0);
        ack_cyc = cyc;
        off = addr - BASE;
        if (collide && rq == 5'd1 && addr >= BASE && off < SPAN) begin
            r = rand64();
            init_we = 1'b1; init_addr = 11'(off >> 3); init_data = r;
            mem[off >> 3] = r;
        end
        @(negedge clk);
        init_we = 1'b0;
        chk("ack_single_pulse", 64'(ack), 64'd0);
    endtask

    task automatic release_rst();
        exp_t w;
        @(negedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
        w.rt = 4'd7; w.d0 = '0; w.d1 = '0; w.hold = 3; w.lat = WD; w.wake = 1;
        sb.push_back(w);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_header_ack"}, 64'(header_ack), 64'd0);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_val"}, 64'(r_val), 64'd0);
        chk({tag, "_rt"}, 64'(rt), 64'd0);
        chk({tag, "_d0"}, d0, 64'd0);
        chk({tag, "_d1"}, d1, 64'd0);
    endtask

    task automatic mid_reset(input string tag);
        #1 rst = 1'b1;
        #1 zero_outputs(tag);
        sb.delete();
        repeat (2) @(negedge clk);
        release_rst();
    endtask

    // Monitor: pops one expectation per response, checks it each held cycle.
    initial begin
        t_req_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 0; after_ack = 0; t_req_ack = 1'b0;
                continue;
            end
            if (after_ack) begin
                chk("val_drop_after_req_ack", 64'(r_val), 64'd0);
                chk("header_ack_after_resp", 64'(header_ack), 64'd1);
                after_ack = 0;
            end
            if (r_val !== 1'b1) begin
                t_req_ack = ($urandom_range(0, 3) == 0);
                continue;
            end
            if (!holding) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_response: got rt=%h with empty scoreboard", rt);
                    t_req_ack = 1'b1; after_ack = 1;
                    continue;
                end
                cur = sb.pop_front();
                holding = 1;
                left = cur.hold;
                chk("response_latency", 64'(cyc - (cur.wake ? rel_cyc : ack_cyc)), 64'(cur.lat));
            end
            chk("returntype", 64'(rt), 64'(cur.rt));
            chk("data_0", d0, cur.d0);
            chk("data_1", d1, cur.d1);
            chk("header_ack_while_resp", 64'(header_ack), 64'd0);
            if (left == 0) begin
                t_req_ack = 1'b1; holding = 0; after_ack = 1;
            end else begin
                left--;
                t_req_ack = 1'b0;
            end
        end
    end

    initial begin
        int          n, r;
        logic [31:0] a;
        logic [4:0]  q;
        rst = 1'b1; t_val = 1'b0; t_rqtype = '0; t_size = '0; t_addr = '0; t_data = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        repeat (3) @(negedge clk);
        zero_outputs("reset");

        for (int i = 0; i < NDW; i++) begin
            mem[i] = (i == 0) ? 64'h0000_0033_0010_0093 :
                     (i == 1) ? 64'h0020_0113_0030_0193 : rand64();
            init_we = 1'b1; init_addr = 11'(i); init_data = mem[i];
            @(negedge clk);
        end
        init_we = 1'b0;
        release_rst();

        issue(5'd0, 32'h4000_0008, rand64(), 0, 0);
        issue(5'd1, 32'h4000_0018, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);
        issue(5'd0, 32'h4000_0010, rand64(), 0, 0);
        issue(5'd0, BASE + 32'h120, rand64(), 5, 0);
        issue(5'd0, 32'h3FFF_FFF0, rand64(), 0, 0);
        issue(5'd0, BASE + SPAN, rand64(), 1, 0);
        issue(5'd0, BASE + SPAN - 32'd1, rand64(), 0, 0);
        issue(5'd9, BASE + 32'h20, rand64(), 0, 0);
        issue(5'd0, BASE + 32'h20, rand64(), 0, 0);
        issue(5'd1, BASE + 32'h48, rand64(), 0, 1);
        issue(5'd0, BASE + 32'h40, rand64(), 2, 0);

        // Reset while waiting out the response latency.
        t_val = 1'b1; t_rqtype = 5'd0; t_addr = BASE + 32'h30;
        n = 0;
        while (header_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        t_val = 1'b0;
        chk("ack_before_reset", 64'(ack), 64'd1);
        @(negedge clk);
        mid_reset("reset_in_lat");
        issue(5'd0, BASE + 32'h30, rand64(), 0, 0);

        // Reset while a response is being held.
        issue(5'd0, BASE + 32'h200, rand64(), 8, 0);
        n = 0;
        while (r_val !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        mid_reset("reset_in_resp");
        issue(5'd0, 32'h4000_0000, rand64(), 0, 0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'($urandom_range(0, 32'h3FFF_FFFF)) :
                (r == 1) ? BASE + SPAN + 32'($urandom_range(0, 32'h000F_FFFF)) :
                           BASE + 32'($urandom_range(0, 32'h3FFF));
            r = $urandom_range(0, 19);
            q = (r < 10) ? 5'd0 : (r < 17) ? 5'd1 : 5'($urandom_range(2, 31));
            issue(q, a, rand64(), $urandom_range(0, 3), (q == 5'd1) && ($urandom_range(0, 9) == 0));
        end

        n = 0;
        while ((sb.size() != 0 || holding) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
